uart9_rx: RTL and testbench

9-bit asynchronous serial receiver with a small receive FIFO, feeding the RX unload state machine in the top level. Oversamples `rx_in` at 16× baud on `ct_rxclk`, frames start / 9 data bits (LSB first) / stop, and queues each good word. Bit 8 of each word is the control flag consumed by the message decoder downstream. Presents the `uld_rx_data` / `rx_data` / `rx_empty` handshake the unloader expects.

---
 rtl/uart9_rx.sv | 172 +++++++++++++++++
 tb/tb_uart9_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart9_rx.sv
// uart9_rx: 9-bit async serial receiver, 16x oversampled, with a small
// receive FIFO and the uld_rx_data / rx_data / rx_empty unload handshake.
module uart9_rx #(
  parameter int DEPTH = 4,
  parameter int OVS   = 16
) (
  input  logic       ct_rxclk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       rx_in,
  input  logic       uld_rx_data,
  output logic [8:0] rx_data,
  output logic       rx_empty,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int CW = $clog2(OVS);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      bitn, bitn_nxt;
  logic [8:0]      shift, shift_nxt;
  logic            stop_ok, stop_bad;
  logic            s1, s2, rxs;

  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count, count_nxt;
  logic            full, pop, push, ovr_set;

  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
    end
  end
  assign rxs = s2;

  // receive FSM state, counters and shift register
  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bitn  <= bitn_nxt;
      shift <= shift_nxt;
    end
  end

  // next-state: start validated at mid-bit, data/stop sampled every OVS cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bitn_nxt  = bitn;
    shift_nxt = shift;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    if (!rx_enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      bitn_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_HALF) begin
            if (!rxs) begin
              state_nxt = DATA;
              cnt_nxt   = '0;
              bitn_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DATA: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            shift_nxt[bitn] = rxs;
            cnt_nxt         = '0;
            if (bitn == 4'd8) state_nxt = STOP;
            else              bitn_nxt  = bitn + 1'b1;
          end
        end
        STOP: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (rxs) begin
              stop_ok   = 1'b1;
              state_nxt = IDLE;
            end else begin
              stop_bad  = 1'b1;
              state_nxt = BRK;
            end
          end
        end
        BRK: begin
          // a held-low break must end before a new start can be seen
          if (rxs) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

  // a pop on a full FIFO frees the slot for a same-edge push
  assign full    = (count == FULL_CNT);
  assign pop     = uld_rx_data && (count != '0);
  assign push    = stop_ok && (!full || pop);
  assign ovr_set = stop_ok && full && !pop;

  // occupancy next-state, also drives registered rx_empty
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // FIFO storage
  always_ff @(posedge ct_rxclk) begin
    if (push) mem[wptr] <= shift;
  end

  // FIFO pointers, output word, empty and sticky flags (set beats clear)
  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rx_data      <= '0;
      rx_empty     <= 1'b1;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      rx_empty <= (count_nxt == '0);
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        rx_data <= mem[rptr];
      end
      if (ovr_set)   rx_overrun <= 1'b1;
      else if (pop)  rx_overrun <= 1'b0;
      if (stop_bad)  rx_frame_err <= 1'b1;
      else if (pop)  rx_frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart9_rx.sv
// Directed bench for uart9_rx: framing, FIFO, flags, aborts and unload handshake.
module tb_uart9_rx;
  localparam int OVS   = 16;
  localparam int DEPTH = 4;

  logic       ct_rxclk = 1'b0;
  logic       reset, rx_enable, rx_in, uld_rx_data;
  logic [8:0] rx_data;
  logic       rx_empty, rx_overrun, rx_frame_err, rx_busy;
  int         checks = 0, failures = 0;
  int         lat;
  logic       saw;

  always #5 ct_rxclk = ~ct_rxclk;

  uart9_rx #(.DEPTH(DEPTH), .OVS(OVS)) dut (
    .ct_rxclk(ct_rxclk), .reset(reset), .rx_enable(rx_enable), .rx_in(rx_in),
    .uld_rx_data(uld_rx_data), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ct_rxclk);
  endtask

  // call at a negedge; start, 9 bits LSB first, stop, OVS cycles each
  task automatic send_frame(input logic [8:0] w, input logic stop);
    rx_in = 1'b0;
    idle(OVS);
    for (int i = 0; i < 9; i++) begin
      rx_in = w[i];
      idle(OVS);
    end
    rx_in = stop;
    idle(OVS);
    rx_in = 1'b1;
  endtask

  // one-cycle uld pulse; returns at the negedge after the sampling edge
  task automatic pop;
    uld_rx_data = 1'b1;
    @(negedge ct_rxclk);
    uld_rx_data = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rx_enable = 1'b1; rx_in = 1'b1; uld_rx_data = 1'b0;
    idle(3);
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_empty", 32'(rx_empty), 32'd1);
    check("rst_ovr",   32'(rx_overrun), 32'd0);
    check("rst_ferr",  32'(rx_frame_err), 32'd0);
    check("rst_busy",  32'(rx_busy), 32'd0);
    reset = 1'b1;
    idle(4);

    // single frame and word latency
    lat = 0;
    fork
      send_frame(9'h17E, 1'b1);
      begin
        while (rx_empty === 1'b1 && lat < 400) begin
          @(posedge ct_rxclk); #1; lat++;
        end
      end
    join
    check("lat_window", 32'((lat >= 170) && (lat <= 172)), 32'd1);
    idle(4);
    pop;
    check("single_data",  32'(rx_data), 32'h17E);
    check("single_empty", 32'(rx_empty), 32'd1);

    // burst of five into a 4-deep FIFO
    send_frame(9'h17E, 1'b1);
    send_frame(9'h003, 1'b1);
    send_frame(9'h0A5, 1'b1);
    send_frame(9'h15A, 1'b1);
    send_frame(9'h17D, 1'b1);
    idle(4);
    check("burst_ovr",  32'(rx_overrun), 32'd1);
    check("burst_ferr", 32'(rx_frame_err), 32'd0);
    pop;
    check("burst_d0",   32'(rx_data), 32'h17E);
    check("burst_ovr_clr", 32'(rx_overrun), 32'd0);
    idle(2); pop;
    check("burst_d1",   32'(rx_data), 32'h003);
    idle(2); pop;
    check("burst_d2",   32'(rx_data), 32'h0A5);
    idle(2); pop;
    check("burst_d3",   32'(rx_data), 32'h15A);
    check("burst_empty", 32'(rx_empty), 32'd1);
    idle(2);

    // framing error followed by a long break
    send_frame(9'h0F0, 1'b0);
    rx_in = 1'b0;
    idle(40 * OVS);
    check("brk_busy",  32'(rx_busy), 32'd1);
    check("brk_empty", 32'(rx_empty), 32'd1);
    check("brk_ferr",  32'(rx_frame_err), 32'd1);
    rx_in = 1'b1;
    idle(8);
    check("brk_idle",  32'(rx_busy), 32'd0);
    send_frame(9'h001, 1'b1);
    idle(4);
    check("ferr_hold", 32'(rx_frame_err), 32'd1);
    pop;
    check("after_brk_data", 32'(rx_data), 32'h001);
    check("ferr_clr",  32'(rx_frame_err), 32'd0);
    idle(4);

    // false start glitch
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ct_rxclk);
      if (rx_busy) saw = 1'b1;
    end
    check("fs_pulse", 32'(saw), 32'd1);
    check("fs_busy",  32'(rx_busy), 32'd0);
    check("fs_empty", 32'(rx_empty), 32'd1);
    check("fs_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);

    // rx_enable drop mid-DATA
    fork
      send_frame(9'h1FF, 1'b1);
      begin
        idle(60);
        check("abort_busy_pre", 32'(rx_busy), 32'd1);
        rx_enable = 1'b0;
        @(negedge ct_rxclk);
        check("abort_busy", 32'(rx_busy), 32'd0);
      end
    join
    rx_enable = 1'b1;
    idle(30);
    check("abort_empty", 32'(rx_empty), 32'd1);
    check("abort_flags", 32'({rx_overrun, rx_frame_err, rx_busy}), 32'd0);

    // asynchronous reset mid-frame with a word queued
    send_frame(9'h0A5, 1'b1);
    idle(4);
    check("pre_rst_empty", 32'(rx_empty), 32'd0);
    fork
      send_frame(9'h1FF, 1'b1);
      begin
        idle(60);
        #2 reset = 1'b0;
        #1;
        check("mrst_data",  32'(rx_data), 32'h0);
        check("mrst_empty", 32'(rx_empty), 32'd1);
        check("mrst_busy",  32'(rx_busy), 32'd0);
        check("mrst_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
      end
    join
    idle(2);
    reset = 1'b1;
    idle(4);

    // pop on empty leaves rx_data alone
    send_frame(9'h0A5, 1'b1);
    idle(4);
    pop;
    check("pe_first", 32'(rx_data), 32'h0A5);
    idle(2);
    pop;
    check("pe_data",  32'(rx_data), 32'h0A5);
    check("pe_empty", 32'(rx_empty), 32'd1);
    check("pe_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
    idle(2);

    // full FIFO: pop lands on the push edge of the fifth word
    send_frame(9'h010, 1'b1);
    send_frame(9'h020, 1'b1);
    send_frame(9'h040, 1'b1);
    send_frame(9'h080, 1'b1);
    fork
      send_frame(9'h1AB, 1'b1);
      begin
        idle(170);
        uld_rx_data = 1'b1;
        @(negedge ct_rxclk);
        uld_rx_data = 1'b0;
      end
    join
    idle(4);
    check("pp_ovr",   32'(rx_overrun), 32'd0);
    check("pp_data",  32'(rx_data), 32'h010);
    check("pp_empty", 32'(rx_empty), 32'd0);
    idle(2); pop;
    check("pp_d1", 32'(rx_data), 32'h020);
    idle(2); pop;
    check("pp_d2", 32'(rx_data), 32'h040);
    idle(2); pop;
    check("pp_d3", 32'(rx_data), 32'h080);
    check("pp_not_empty", 32'(rx_empty), 32'd0);
    idle(2); pop;
    check("pp_d4", 32'(rx_data), 32'h1AB);
    check("pp_empty_end", 32'(rx_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
